// File: rtl/bcd_stopwatch_core.sv
// BCD stopwatch core: debounced start/stop and clear keys, a 1 kHz based
// 0.01 s prescaler and a four-digit BCD count (00.00 .. 99.99) that
// saturates at 99.99.
`timescale 1ns/1ps

module bcd_stopwatch_core #(
    parameter int DEB_MS = 20,
    parameter int PRESC  = 10
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1k,
    input  logic       key_ss,
    input  logic       key_clr,
    output logic [3:0] data0,
    output logic [3:0] data1,
    output logic [3:0] data2,
    output logic [3:0] data3,
    output logic       running,
    output logic       full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST   = 8'(DEB_MS - 1);
    localparam logic [7:0] PRESC_LAST = 8'(PRESC - 1);

    // Key bit 0 is start/stop, bit 1 is clear.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic [7:0] deb_cnt [2];
    logic [1:0] press;
    logic       ss_press;
    logic       clr_press;

    state_t     state;
    logic [7:0] presc;
    logic       step;
    logic       at_last;
    logic [3:0] inc0;
    logic [3:0] inc1;
    logic [3:0] inc2;
    logic [3:0] inc3;

    // Two-flop synchronizers for the raw asynchronous buttons.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {key_clr, key_ss};
            sync2 <= sync1;
        end
    end

    // Debounce: the stable level follows the synchronized key only after
    // DEB_MS consecutive 1 kHz samples disagree with the current level.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            if (tick_1k) begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2[i] == stable[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Rising edge of a debounced level is a press; clear masks start/stop.
    assign press     = stable & ~stable_d;
    assign clr_press = press[1];
    assign ss_press  = press[0] & ~press[1];

    assign step = (state == RUN) && tick_1k && (presc == PRESC_LAST);

    // Ripple BCD increment with same-cycle carry; also flag 99.98 so the
    // step that lands on 99.99 can enter FULL on the same edge.
    always_comb begin
        inc0 = (data0 == 4'd9) ? 4'd0 : data0 + 4'd1;
        inc1 = data1;
        inc2 = data2;
        inc3 = data3;
        if (data0 == 4'd9) begin
            inc1 = (data1 == 4'd9) ? 4'd0 : data1 + 4'd1;
            if (data1 == 4'd9) begin
                inc2 = (data2 == 4'd9) ? 4'd0 : data2 + 4'd1;
                if (data2 == 4'd9) begin
                    inc3 = (data3 == 4'd9) ? 4'd0 : data3 + 4'd1;
                end
            end
        end
        at_last = (data3 == 4'd9) && (data2 == 4'd9) &&
                  (data1 == 4'd9) && (data0 == 4'd8);
    end

    // Stopwatch FSM with registered status flags, prescaler and digits.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= '0;
            data0   <= '0;
            data1   <= '0;
            data2   <= '0;
            data3   <= '0;
            running <= 1'b0;
            full    <= 1'b0;
        end else if (clr_press) begin
            state   <= IDLE;
            presc   <= '0;
            data0   <= '0;
            data1   <= '0;
            data2   <= '0;
            data3   <= '0;
            running <= 1'b0;
            full    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (ss_press) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick_1k) begin
                        presc <= (presc == PRESC_LAST) ? 8'd0 : presc + 8'd1;
                    end
                    if (step) begin
                        data0 <= inc0;
                        data1 <= inc1;
                        data2 <= inc2;
                        data3 <= inc3;
                    end
                    if (step && at_last) begin
                        state   <= FULL;
                        presc   <= '0;
                        running <= 1'b0;
                        full    <= 1'b1;
                    end else if (ss_press) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (ss_press) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                FULL: begin
                    presc <= '0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    full    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core: a default-parameter instance for
// counting, pause, bounce and clear, and a PRESC=1 / DEB_MS=2 instance for
// long runs (saturation, async reset at 45.67, step plus ss in one cycle).
`timescale 1ns/1ps

module tb_bcd_stopwatch_core;

    logic       clk = 1'b0;

    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       key_ss = 1'b0;
    logic       key_clr = 1'b0;
    logic [3:0] d0, d1, d2, d3;
    logic       running, full;

    logic       rst_f = 1'b0;
    logic       tick_f = 1'b0;
    logic       key_ss_f = 1'b0;
    logic       key_clr_f = 1'b0;
    logic [3:0] f0, f1, f2, f3;
    logic       running_f, full_f;

    int checks = 0;
    int errors = 0;

    logic [15:0] cnt;
    logic [15:0] cnt_f;
    assign cnt   = {d3, d2, d1, d0};
    assign cnt_f = {f3, f2, f1, f0};

    always #5 clk = ~clk;

    bcd_stopwatch_core #(.DEB_MS(20), .PRESC(10)) dut (
        .clk_in  (clk),
        .rst     (rst),
        .tick_1k (tick),
        .key_ss  (key_ss),
        .key_clr (key_clr),
        .data0   (d0),
        .data1   (d1),
        .data2   (d2),
        .data3   (d3),
        .running (running),
        .full    (full)
    );

    bcd_stopwatch_core #(.DEB_MS(2), .PRESC(1)) dut_f (
        .clk_in  (clk),
        .rst     (rst_f),
        .tick_1k (tick_f),
        .key_ss  (key_ss_f),
        .key_clr (key_clr_f),
        .data0   (f0),
        .data1   (f1),
        .data2   (f2),
        .data3   (f3),
        .running (running_f),
        .full    (full_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick: high for one rising edge, low for the following one.
    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic fticks(input int n);
        repeat (n) begin
            tick_f = 1'b1;
            @(negedge clk);
            tick_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        cyc(2);
        chk("reset_count", cnt, 16'h0000);
        chk("reset_running", running, 1'b0);
        chk("reset_full", full, 1'b0);
        rst   = 1'b1;
        rst_f = 1'b1;
        cyc(2);

        // Count: held key, 1000 ticks -> 01.00; release adds 20 ticks, no pulse
        key_ss = 1'b1;
        cyc(3);
        ticks(20);
        chk("start_running", running, 1'b1);
        chk("start_count", cnt, 16'h0000);
        ticks(1000);
        chk("count_1000", cnt, 16'h0100);
        chk("count_running", running, 1'b1);
        key_ss = 1'b0;
        cyc(3);
        ticks(20);
        chk("release_no_pulse", cnt, 16'h0102);
        chk("release_running", running, 1'b1);

        // Pause at 00.37 with prescaler phase 5
        rst_pulse();
        key_ss = 1'b1;
        cyc(3);
        ticks(20);
        ticks(335);
        key_ss = 1'b0;
        cyc(3);
        ticks(20);
        key_ss = 1'b1;
        cyc(3);
        ticks(20);
        chk("pause_count", cnt, 16'h0037);
        chk("pause_running", running, 1'b0);
        ticks(500);
        chk("pause_hold", cnt, 16'h0037);
        key_ss = 1'b0;
        cyc(3);
        ticks(20);
        key_ss = 1'b1;
        cyc(3);
        ticks(20);
        chk("resume_count", cnt, 16'h0037);
        chk("resume_running", running, 1'b1);
        ticks(4);
        chk("resume_phase_a", cnt, 16'h0037);
        ticks(1);
        chk("resume_phase_b", cnt, 16'h0038);

        // Bounce: toggle every 3 ticks for 15 ticks, then hold 25 ticks
        rst_pulse();
        for (int s = 0; s < 5; s++) begin
            key_ss = (s % 2 == 0);
            ticks(3);
        end
        key_ss = 1'b1;
        ticks(25);
        chk("bounce_running", running, 1'b1);
        chk("bounce_count", cnt, 16'h0000);
        ticks(3);
        chk("bounce_phase", cnt, 16'h0001);

        // Clear and ss pressed together while running
        key_ss = 1'b0;
        cyc(3);
        ticks(20);
        chk("pre_clr_count", cnt, 16'h0003);
        key_ss  = 1'b1;
        key_clr = 1'b1;
        cyc(3);
        ticks(20);
        chk("clr_prio_count", cnt, 16'h0000);
        chk("clr_prio_running", running, 1'b0);
        chk("clr_prio_full", full, 1'b0);
        key_ss  = 1'b0;
        key_clr = 1'b0;
        cyc(3);
        ticks(20);
        ticks(10);
        chk("idle_no_count", cnt, 16'h0000);

        // Fast instance: run to 45.67, then asynchronous reset between edges
        key_ss_f = 1'b1;
        cyc(3);
        fticks(2);
        fticks(4567);
        chk("f_count_4567", cnt_f, 16'h4567);
        chk("f_running_4567", running_f, 1'b1);
        @(posedge clk);
        #2;
        rst_f = 1'b0;
        #1;
        chk("async_count", cnt_f, 16'h0000);
        chk("async_running", running_f, 1'b0);
        chk("async_full", full_f, 1'b0);
        @(negedge clk);
        cyc(1);
        rst_f = 1'b1;

        // Key held through reset gives one press once debounced
        cyc(3);
        fticks(2);
        chk("post_rst_running", running_f, 1'b1);
        chk("post_rst_count", cnt_f, 16'h0000);

        // Saturation
        fticks(9998);
        chk("f_count_9998", cnt_f, 16'h9998);
        chk("f_running_9998", running_f, 1'b1);
        fticks(1);
        chk("sat_count", cnt_f, 16'h9999);
        chk("sat_full", full_f, 1'b1);
        chk("sat_running", running_f, 1'b0);
        fticks(5);
        chk("sat_hold", cnt_f, 16'h9999);
        key_ss_f = 1'b0;
        cyc(3);
        fticks(2);
        key_ss_f = 1'b1;
        cyc(3);
        fticks(2);
        chk("sat_ss_count", cnt_f, 16'h9999);
        chk("sat_ss_full", full_f, 1'b1);
        chk("sat_ss_running", running_f, 1'b0);
        key_clr_f = 1'b1;
        cyc(3);
        fticks(2);
        chk("sat_clr_count", cnt_f, 16'h0000);
        chk("sat_clr_full", full_f, 1'b0);
        key_clr_f = 1'b0;
        key_ss_f  = 1'b0;

        // Step and ss pulse in the same cycle: both take effect
        rst_f = 1'b0;
        cyc(2);
        rst_f = 1'b1;
        cyc(2);
        tick_f   = 1'b1;
        key_ss_f = 1'b1;
        cyc(10);
        chk("cont_run", cnt_f, 16'h0005);
        key_ss_f = 1'b0;
        cyc(10);
        chk("cont_release", cnt_f, 16'h0015);
        key_ss_f = 1'b1;
        cyc(5);
        chk("step_ss_count", cnt_f, 16'h0020);
        chk("step_ss_running", running_f, 1'b0);
        cyc(5);
        chk("step_ss_hold", cnt_f, 16'h0020);
        tick_f = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
